// File: rtl/write_buffer.sv
// write_buffer: write-through FIFO between the data cache and the backing RAM.
// Cache writes are captured into a DEPTH-entry circular buffer and drained to
// RAM one at a time (mem_wr held until mem_ack). A combinational probe port
// lets the miss-fill logic detect pending writes to the fill address.
// Optional feature macro: WBUF_FWD_EN builds the lk_data forwarding mux;
// without it lk_data is tied to zero and lk_hit is only a hazard flag.
module write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [10:0]      req_addr,
    input  logic [7:0]       req_data,
    output logic             req_ready,
    output logic             mem_wr,
    output logic [10:0]      mem_addr,
    output logic [7:0]       mem_din,
    input  logic             mem_ack,
    input  logic [10:0]      lk_addr,
    output logic             lk_hit,
    output logic [7:0]       lk_data,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

    state_t           r_state, w_state_nxt;
    logic [DEPTH-1:0] r_valid;
    logic [10:0]      r_addr [DEPTH];
    logic [7:0]       r_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [10:0]      r_mem_addr;
    logic [7:0]       r_mem_din;

    logic             w_push, w_pop, w_load, w_head_new;
    logic [PTR_W:0]   w_count_nxt;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [PTR_W-1:0] w_idx;
    logic             w_hit;

    // Handshake qualifiers; ready looks only at the registered count
    assign req_ready = (r_count != FULL_CNT);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_ISSUE) && mem_ack;
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;

    // Drain FSM next state, mem_wr, and head-register load control
    always_comb begin
        w_count_nxt = r_count;
        w_rd_nxt    = r_rd_ptr;
        mem_wr      = 1'b0;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_CNT;
            2'b01:   w_count_nxt = r_count - ONE_CNT;
            default: w_count_nxt = r_count;
        endcase
        if (w_pop)
            w_rd_nxt = r_rd_ptr + PTR_W'(1);
        if (r_state == S_ISSUE)
            mem_wr = 1'b1;
        // Both states leave for ISSUE exactly when something remains pending
        w_state_nxt = (w_count_nxt != '0) ? S_ISSUE : S_IDLE;
        w_load      = (w_state_nxt == S_ISSUE) && ((r_state == S_IDLE) || w_pop);
        // If nothing else remains after this edge's pop, the new head is the
        // entry being pushed right now, which is not yet in storage
        w_head_new  = w_push && ((r_count == '0) || (w_pop && r_count == ONE_CNT));
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Storage, pointers and count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_pop)
                r_valid[r_rd_ptr] <= 1'b0;
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_addr[r_wr_ptr]  <= req_addr;
                r_data[r_wr_ptr]  <= req_data;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Registered RAM request: reload on entering ISSUE and on every ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else if (w_load) begin
            if (w_head_new) begin
                r_mem_addr <= req_addr;
                r_mem_din  <= req_data;
            end else begin
                r_mem_addr <= r_addr[w_rd_nxt];
                r_mem_din  <= r_data[w_rd_nxt];
            end
        end
    end

`ifdef WBUF_FWD_EN
    logic [7:0] w_fwd;

    // Probe: scan oldest to youngest so the last match (youngest) wins
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PTR_W'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == lk_addr)) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    assign lk_data = w_fwd;
`else
    // Probe: hazard flag only, no data forwarding
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PTR_W'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == lk_addr))
                w_hit = 1'b1;
        end
    end

    assign lk_data = '0;
`endif

    assign lk_hit = w_hit;

endmodule
